// File: rtl/readout_scheduler_pkg.sv
// Shared constants, settings bit positions and FSM state type for the readout scheduler.
// The timeout and register map values are defaults; the top exposes them as parameters.
package readout_scheduler_pkg;

    localparam int REG_ADDR_WIDTH_DEF = 8;
    localparam int REG_DATA_WIDTH_DEF = 16;
    localparam int TIMEOUT_WIDTH_DEF  = 24;

    localparam logic [REG_ADDR_WIDTH_DEF-1:0] ADDR_READOUT_SETTINGS_DEF    = 8'h10;
    localparam logic [REG_DATA_WIDTH_DEF-1:0] DEFAULT_READOUT_SETTINGS_DEF = 16'h0006;
    localparam logic [TIMEOUT_WIDTH_DEF-1:0]  RO_TIMEOUT_CYCLES            = 24'd1000000;

    localparam int RO_AUTO_EN      = 0;
    localparam int RO_INCL_CHA     = 1;
    localparam int RO_INCL_CHB     = 2;
    localparam int RO_INCL_STATUS  = 3;

    // pending / select vectors are ordered {B, A, S}
    localparam int SRC_S = 0;
    localparam int SRC_A = 1;
    localparam int SRC_B = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } ro_state_t;

    // One-hot of the lowest set bit, which gives S > A > B priority.
    function automatic logic [2:0] lowest_set(input logic [2:0] v);
        return v & (~v + 3'd1);
    endfunction

endpackage

// File: rtl/readout_settings_reg.sv
// Single-address settings register on the shared register bus.
// settings_wr is the raw decoded strobe so the owner can react in the same cycle.
module readout_settings_reg #(
    parameter int                      ADDR_WIDTH  = 8,
    parameter int                      DATA_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0]   REG_ADDR    = 8'h10,
    parameter logic [DATA_WIDTH-1:0]   REG_DEFAULT = 16'h0006
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] register_addr,
    input  logic [DATA_WIDTH-1:0] register_data,
    input  logic                  register_rdy,
    output logic [DATA_WIDTH-1:0] settings,
    output logic                  settings_wr
);

    assign settings_wr = register_rdy && (register_addr == REG_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            settings <= REG_DEFAULT;
        end else if (settings_wr) begin
            settings <= register_data;
        end
    end

endmodule

// File: rtl/readout_scheduler.sv
// Serialises status / chA / chB readout requests, one source in flight at a time,
// with per-item timeout, optional auto start on capture completion and host abort.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_IDLE  | nothing in flight; pick lowest pending source if any
//  ST_ISSUE | one-cycle request pulse to the selected source, load timer
//  ST_WAIT  | wait for selected source's eof beat or timer expiry
module readout_scheduler
    import readout_scheduler_pkg::*;
#(
    parameter int                          REG_ADDR_WIDTH           = REG_ADDR_WIDTH_DEF,
    parameter int                          REG_DATA_WIDTH           = REG_DATA_WIDTH_DEF,
    parameter logic [REG_ADDR_WIDTH-1:0]   ADDR_READOUT_SETTINGS    = ADDR_READOUT_SETTINGS_DEF,
    parameter logic [REG_DATA_WIDTH-1:0]   DEFAULT_READOUT_SETTINGS = DEFAULT_READOUT_SETTINGS_DEF,
    parameter int                          TIMEOUT_WIDTH            = TIMEOUT_WIDTH_DEF,
    parameter logic [TIMEOUT_WIDTH-1:0]    TIMEOUT_CYCLES           = RO_TIMEOUT_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] register_addr,
    input  logic [REG_DATA_WIDTH-1:0] register_data,
    input  logic                      register_rdy,
    input  logic                      host_rqst_status,
    input  logic                      host_rqst_chA,
    input  logic                      host_rqst_chB,
    input  logic                      abort,
    input  logic                      capture_done,
    input  logic                      status_rdy,
    input  logic                      status_eof,
    input  logic                      status_ack,
    input  logic                      chA_rdy,
    input  logic                      chA_eof,
    input  logic                      chA_ack,
    input  logic                      chB_rdy,
    input  logic                      chB_eof,
    input  logic                      chB_ack,
    output logic                      rqst_status_o,
    output logic                      rqst_chA_o,
    output logic                      rqst_chB_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      timeout_err_o
);

    localparam logic [TIMEOUT_WIDTH-1:0] TIMER_ONE = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};

    logic [REG_DATA_WIDTH-1:0] settings;
    logic                      settings_wr;

    readout_settings_reg #(
        .ADDR_WIDTH  (REG_ADDR_WIDTH),
        .DATA_WIDTH  (REG_DATA_WIDTH),
        .REG_ADDR    (ADDR_READOUT_SETTINGS),
        .REG_DEFAULT (DEFAULT_READOUT_SETTINGS)
    ) u_settings_reg (
        .clk           (clk),
        .rst           (rst),
        .register_addr (register_addr),
        .register_data (register_data),
        .register_rdy  (register_rdy),
        .settings      (settings),
        .settings_wr   (settings_wr)
    );

    ro_state_t               state_q, state_nxt;
    logic [2:0]              pending_q, pending_nxt;
    logic [2:0]              sel_q, sel_nxt;
    logic [TIMEOUT_WIDTH-1:0] timer_q, timer_nxt;
    logic [2:0]              rqst_q, rqst_nxt;
    logic                    busy_q, busy_nxt;
    logic                    done_q, done_nxt;
    logic                    err_q;

    logic [2:0] eof_vec;
    logic [2:0] host_set;
    logic [2:0] auto_set;
    logic [2:0] pend_set;
    logic [2:0] pend_clr;
    logic       leave_wait;
    logic       timeout_hit;

    assign eof_vec  = {chB_rdy & chB_eof & chB_ack,
                       chA_rdy & chA_eof & chA_ack,
                       status_rdy & status_eof & status_ack};
    assign host_set = {host_rqst_chB, host_rqst_chA, host_rqst_status};
    assign auto_set = (capture_done && settings[RO_AUTO_EN])
                      ? {settings[RO_INCL_CHB], settings[RO_INCL_CHA], settings[RO_INCL_STATUS]}
                      : 3'b000;
    assign pend_set = host_set | auto_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= 3'b000;
            sel_q     <= 3'b000;
            timer_q   <= '0;
            rqst_q    <= 3'b000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            pending_q <= pending_nxt;
            sel_q     <= sel_nxt;
            timer_q   <= timer_nxt;
            rqst_q    <= rqst_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
            // a fresh timeout outranks a clearing settings write in the same cycle
            if (timeout_hit) begin
                err_q <= 1'b1;
            end else if (settings_wr) begin
                err_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt   = state_q;
        sel_nxt     = sel_q;
        timer_nxt   = timer_q;
        pend_clr    = 3'b000;
        rqst_nxt    = 3'b000;
        leave_wait  = 1'b0;
        timeout_hit = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pending_q != 3'b000) begin
                    sel_nxt   = lowest_set(pending_q);
                    pend_clr  = sel_nxt;
                    rqst_nxt  = sel_nxt;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                timer_nxt = TIMEOUT_CYCLES;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if ((sel_q & eof_vec) != 3'b000) begin
                    leave_wait = 1'b1;
                    state_nxt  = ST_IDLE;
                end else if (timer_q <= TIMER_ONE) begin
                    timer_nxt   = '0;
                    timeout_hit = 1'b1;
                    leave_wait  = 1'b1;
                    state_nxt   = ST_IDLE;
                end else begin
                    timer_nxt = timer_q - TIMER_ONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // set beats clear so a re-request of the source being picked is kept
        pending_nxt = (pending_q & ~pend_clr) | pend_set;
        done_nxt    = leave_wait && (pending_nxt == 3'b000);

        if (abort) begin
            pending_nxt = 3'b000;
            state_nxt   = ST_IDLE;
            rqst_nxt    = 3'b000;
            done_nxt    = 1'b0;
            timeout_hit = 1'b0;
        end

        busy_nxt = (state_nxt != ST_IDLE) || (pending_nxt != 3'b000);
    end

    assign rqst_status_o = rqst_q[SRC_S];
    assign rqst_chA_o    = rqst_q[SRC_A];
    assign rqst_chB_o    = rqst_q[SRC_B];
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign timeout_err_o = err_q;

endmodule
